// File: rtl/pwm_compare_pkg.sv
// pwm_compare_pkg
// Shared definitions for the PWM compare block: reload-mode encodings,
// comparator polarity and the register-map offsets. The broadcast and mode
// registers sit directly above the per-channel low/high banks. Their
// addresses depend on the channel count, so helper functions derive them.
package pwm_compare_pkg;

  // Shadow-to-working transfer policy
  typedef enum logic [1:0] {
    RELOAD_ON_EVENT  = 2'd0,  // transfer on reload_compare when pending
    RELOAD_IMMEDIATE = 2'd1,  // writes land in shadow and working together
    RELOAD_HOLD      = 2'd2,  // writes stay in shadow, no transfer
    RELOAD_EVENT_ALT = 2'd3   // reserved encoding, behaves as on-event
  } reload_mode_e;

  // Comparator direction for one channel
  typedef enum logic {
    CMP_BELOW = 1'b0,  // match when counter < compare value
    CMP_ABOVE = 1'b1   // match when counter > compare value
  } cmp_polarity_e;

  // Offsets of the control registers relative to the end of the two banks (2*N)
  localparam int unsigned BCAST_LOW_OFFSET  = 32'd0;
  localparam int unsigned BCAST_HIGH_OFFSET = 32'd1;
  localparam int unsigned MODE_OFFSET       = 32'd2;

  // First address of the high bank
  function automatic int unsigned high_base_addr(input int unsigned n_ch);
    return n_ch;
  endfunction

  // Broadcast-to-all-low address
  function automatic int unsigned bcast_low_addr(input int unsigned n_ch);
    return 32'd2 * n_ch + BCAST_LOW_OFFSET;
  endfunction

  // Broadcast-to-all-high address
  function automatic int unsigned bcast_high_addr(input int unsigned n_ch);
    return 32'd2 * n_ch + BCAST_HIGH_OFFSET;
  endfunction

  // Reload-mode register address
  function automatic int unsigned mode_addr(input int unsigned n_ch);
    return 32'd2 * n_ch + MODE_OFFSET;
  endfunction

  // Modes that transfer on the period-boundary strobe
  function automatic logic is_event_mode(input reload_mode_e mode);
    return (mode == RELOAD_ON_EVENT) || (mode == RELOAD_EVENT_ALT);
  endfunction

endpackage

// File: rtl/compare_channel.sv
// compare_channel
// One compare register: a shadow/working pair plus a registered comparator.
// A low-threshold channel uses POLARITY = CMP_BELOW and resets to 0. A
// high-threshold channel uses CMP_ABOVE and resets to all-ones. With those
// reset values neither channel matches anywhere in the counter range.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-low reset
//   shadow_we      load data_in into the shadow register
//   working_we     load data_in into the working register (write-through)
//   transfer       copy the shadow register into the working register
//   data_in        write data
//   counter_value  carrier count being compared
//   match          registered compare result against the working register
module compare_channel
  import pwm_compare_pkg::*;
#(
  parameter int unsigned   WIDTH    = 16,
  parameter cmp_polarity_e POLARITY = CMP_BELOW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shadow_we,
  input  logic             working_we,
  input  logic             transfer,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] counter_value,
  output logic             match
);

  localparam logic [WIDTH-1:0] RESET_VALUE =
    (POLARITY == CMP_ABOVE) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] shadow_r;
  logic [WIDTH-1:0] working_r;
  logic             match_r;
  logic [WIDTH-1:0] shadow_next_s;
  logic [WIDTH-1:0] working_next_s;
  logic             hit_s;

  // Next-state selection for shadow and working, plus the raw compare
  always_comb begin
    shadow_next_s  = shadow_r;
    working_next_s = working_r;
    hit_s          = 1'b0;

    if (shadow_we) begin
      shadow_next_s = data_in;
    end else begin
      shadow_next_s = shadow_r;
    end

    // The transfer uses the pre-write shadow, so a write in the same cycle
    // only lands in the shadow and stays there for the next transfer.
    if (working_we) begin
      working_next_s = data_in;
    end else if (transfer) begin
      working_next_s = shadow_r;
    end else begin
      working_next_s = working_r;
    end

    if (POLARITY == CMP_ABOVE) begin
      hit_s = (counter_value > working_r);
    end else begin
      hit_s = (counter_value < working_r);
    end
  end

  // Register state and the compare output
  always_ff @(posedge clock) begin
    if (!reset) begin
      shadow_r  <= RESET_VALUE;
      working_r <= RESET_VALUE;
      match_r   <= 1'b0;
    end else begin
      shadow_r  <= shadow_next_s;
      working_r <= working_next_s;
      match_r   <= hit_s;
    end
  end

  assign match = match_r;

endmodule

// File: rtl/multi_compare_unit.sv
// multi_compare_unit
// A bank of N_CHANNELS low/high compare pairs for a PWM carrier. Each
// register is double-buffered as a shadow and a working copy. A mode
// register decides when shadow contents reach the working copies:
// immediately, on the period strobe, or never. While the counter is halted,
// every compare write goes straight through to the working register.
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-low reset
//   counter_value    PWM carrier count
//   counter_stopped  high while the carrier counter is halted
//   we               write strobe
//   address          register select
//   data_in          write data
//   reload_compare   period-boundary strobe from the counter
//   match_low        bit i = counter_value < low[i], registered
//   match_high       bit i = counter_value > high[i], registered
//   reload_pending   a shadow write is waiting for transfer
//   reload_done      one-cycle pulse after a shadow-to-working transfer
module multi_compare_unit
  import pwm_compare_pkg::*;
#(
  parameter  int unsigned COUNTER_WIDTH = 16,
  parameter  int unsigned N_CHANNELS    = 3,
  localparam int unsigned ADDR_WIDTH    = $clog2(2 * N_CHANNELS + 3)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [COUNTER_WIDTH-1:0] counter_value,
  input  logic                     counter_stopped,
  input  logic                     we,
  input  logic [ADDR_WIDTH-1:0]    address,
  input  logic [COUNTER_WIDTH-1:0] data_in,
  input  logic                     reload_compare,
  output logic [N_CHANNELS-1:0]    match_low,
  output logic [N_CHANNELS-1:0]    match_high,
  output logic                     reload_pending,
  output logic                     reload_done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_BCAST_LOW  = ADDR_WIDTH'(bcast_low_addr(N_CHANNELS));
  localparam logic [ADDR_WIDTH-1:0] ADDR_BCAST_HIGH = ADDR_WIDTH'(bcast_high_addr(N_CHANNELS));
  localparam logic [ADDR_WIDTH-1:0] ADDR_MODE       = ADDR_WIDTH'(mode_addr(N_CHANNELS));

  reload_mode_e          reload_mode_r;
  logic                  reload_pending_r;
  logic                  reload_done_r;

  logic [N_CHANNELS-1:0] low_sel_s;
  logic [N_CHANNELS-1:0] high_sel_s;
  logic                  compare_write_s;
  logic                  mode_write_s;
  logic                  write_through_s;
  logic                  shadow_only_write_s;
  logic                  transfer_s;
  logic                  pending_next_s;
  reload_mode_e          mode_next_s;

  // Address decode: per-channel selects, including the broadcast addresses
  always_comb begin
    low_sel_s  = {N_CHANNELS{1'b0}};
    high_sel_s = {N_CHANNELS{1'b0}};
    for (int i = 0; i < int'(N_CHANNELS); i++) begin
      low_sel_s[i]  = we && ((address == ADDR_WIDTH'(i)) ||
                             (address == ADDR_BCAST_LOW));
      high_sel_s[i] = we && ((address == ADDR_WIDTH'(high_base_addr(N_CHANNELS) + i)) ||
                             (address == ADDR_BCAST_HIGH));
    end
  end

  // Write classification and the transfer condition
  always_comb begin
    compare_write_s     = (|low_sel_s) || (|high_sel_s);
    mode_write_s        = we && (address == ADDR_MODE);
    // A halted counter or immediate mode writes straight to the working copy.
    write_through_s     = counter_stopped || (reload_mode_r == RELOAD_IMMEDIATE);
    shadow_only_write_s = compare_write_s && !write_through_s;
    transfer_s          = reload_compare && reload_pending_r && !counter_stopped &&
                          is_event_mode(reload_mode_r);
  end

  // Next pending flag and next reload mode
  always_comb begin
    pending_next_s = reload_pending_r;
    mode_next_s    = reload_mode_r;

    // A write that coincides with a transfer lands in the shadow after the
    // copy, so the shadow again differs and pending stays set.
    if (transfer_s) begin
      pending_next_s = shadow_only_write_s;
    end else if (shadow_only_write_s) begin
      pending_next_s = 1'b1;
    end else begin
      pending_next_s = reload_pending_r;
    end

    if (mode_write_s) begin
      case (data_in[1:0])
        2'd0:    mode_next_s = RELOAD_ON_EVENT;
        2'd1:    mode_next_s = RELOAD_IMMEDIATE;
        2'd2:    mode_next_s = RELOAD_HOLD;
        2'd3:    mode_next_s = RELOAD_EVENT_ALT;
        default: mode_next_s = RELOAD_ON_EVENT;
      endcase
    end else begin
      mode_next_s = reload_mode_r;
    end
  end

  // Control state: reload mode, pending flag and transfer-done pulse
  always_ff @(posedge clock) begin
    if (!reset) begin
      reload_mode_r    <= RELOAD_ON_EVENT;
      reload_pending_r <= 1'b0;
      reload_done_r    <= 1'b0;
    end else begin
      reload_mode_r    <= mode_next_s;
      reload_pending_r <= pending_next_s;
      reload_done_r    <= transfer_s;
    end
  end

  for (genvar g = 0; g < int'(N_CHANNELS); g++) begin : gen_channel
    compare_channel #(
      .WIDTH    (COUNTER_WIDTH),
      .POLARITY (CMP_BELOW)
    ) u_low (
      .clock         (clock),
      .reset         (reset),
      .shadow_we     (low_sel_s[g]),
      .working_we    (low_sel_s[g] && write_through_s),
      .transfer      (transfer_s),
      .data_in       (data_in),
      .counter_value (counter_value),
      .match         (match_low[g])
    );

    compare_channel #(
      .WIDTH    (COUNTER_WIDTH),
      .POLARITY (CMP_ABOVE)
    ) u_high (
      .clock         (clock),
      .reset         (reset),
      .shadow_we     (high_sel_s[g]),
      .working_we    (high_sel_s[g] && write_through_s),
      .transfer      (transfer_s),
      .data_in       (data_in),
      .counter_value (counter_value),
      .match         (match_high[g])
    );
  end

  assign reload_pending = reload_pending_r;
  assign reload_done    = reload_done_r;

endmodule

// File: doc/multi_compare_unit.md
MULTI_COMPARE_UNIT -- requirements
Module: multi_compare_unit

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 16, width of counter and compare values.
REQ-002 SHALL have parameter N_CHANNELS, default 3, number of low/high compare pairs (1..16).
REQ-003 SHALL derive localparam ADDR_WIDTH = $clog2(2*N_CHANNELS+3).
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 counter_value  input  COUNTER_WIDTH  PWM carrier count.
REQ-007 counter_stopped  input  1  high while the carrier counter is halted.
REQ-008 we  input  1  write strobe, one write per asserted cycle.
REQ-009 address  input  ADDR_WIDTH  register select.
REQ-010 data_in  input  COUNTER_WIDTH  write data.
REQ-011 reload_compare  input  1  period-boundary strobe from the counter.
REQ-012 match_low  output  N_CHANNELS  bit i = counter_value < low[i], registered.
REQ-013 match_high  output  N_CHANNELS  bit i = counter_value > high[i], registered.
REQ-014 reload_pending  output  1  shadow differs from working (a write has occurred since the last transfer).
REQ-015 reload_done  output  1  single-cycle pulse on the cycle after a shadow-to-working transfer.

Function
REQ-016 Address map SHALL be: 0..N-1 low[i]; N..2N-1 high[i-N]; 2N broadcast all low; 2N+1 broadcast all high; 2N+2 reload_mode (data_in[1:0]); higher addresses ignored.
REQ-017 reload_mode SHALL be: 0 = on-event (transfer on reload_compare when pending), 1 = immediate (writes land in shadow and working in the same cycle), 2 = hold (no transfer), 3 = treated as 0.
REQ-018 While counter_stopped = 1, compare writes SHALL update shadow and working in the same cycle regardless of reload_mode, and SHALL NOT set reload_pending.
REQ-019 While counter_stopped = 0, compare writes in modes 0/2 SHALL update shadow only and set reload_pending.
REQ-020 In mode 0, reload_compare with reload_pending = 1 SHALL copy all 2N shadow registers to working atomically, clear reload_pending, and pulse reload_done the next cycle.
REQ-021 reload_compare with reload_pending = 0, in mode 2, or while counter_stopped = 1 SHALL cause no transfer and no reload_done.
REQ-022 Simultaneous write and transfer: the transfer SHALL use pre-write shadow contents, the write SHALL land in shadow, and reload_pending SHALL remain 1.
REQ-023 A write to reload_mode SHALL take effect the following cycle; switching from 2 to 0 SHALL preserve reload_pending.
REQ-024 match_low/match_high SHALL have exactly one cycle of latency from counter_value and the working registers.
REQ-025 Comparisons SHALL be unsigned and full COUNTER_WIDTH, with no wrap-around; low = 0 never matches and high = all-ones never matches.

Reset
REQ-026 On reset = 0 at a clock edge: low shadow/working = 0; high shadow/working = all-ones; reload_mode = 0; reload_pending = 0; reload_done = 0; match_low = 0; match_high = 0.
REQ-027 A reset asserted mid-period SHALL discard any pending transfer.

Structure
REQ-028 Reload-mode encodings and address offset constants SHALL live in shared package pwm_compare_pkg.
REQ-029 Per-channel shadow/working pair plus comparator SHALL be sub-module compare_channel, instantiated 2*N_CHANNELS times by generate, with a polarity parameter selecting < or >.

Verification
REQ-030 Reset then counter sweeping 0..65535 -> match_low = 0 and match_high = 0 throughout.
REQ-031 counter_stopped = 1, write 1000 to addr 0 -> working low[0] = 1000 the next cycle; counter_value = 999 gives match_low[0] = 1 one cycle later; 1000 gives 0.
REQ-032 Running, mode 0, write 500 to addr 2N+1 -> match_high unchanged until reload_compare, then reload_done pulses; counter_value = 501 gives match_high = all-ones.
REQ-033 Write 300 to addr 1 in the same cycle as reload_compare with a prior pending write of 200 -> working low[1] = 200, reload_pending stays 1, and the next reload_compare transfers 300.
REQ-034 Mode 2, write then 3 reload_compare strobes -> no transfer and no reload_done; set mode 0, next strobe transfers.
REQ-035 N_CHANNELS = 6, COUNTER_WIDTH = 24, write 0xFFFFFE to high[5], reload -> match_high[5] = 1 only at counter_value 0xFFFFFF.
